// File: rtl/spi_mem_burst.sv
// rtl/spi_mem_burst.sv - SPI mode-0 burst master for 23LC512-style serial RAM
//
// Purpose: issues one read (RD_CMD) or write (WR_CMD) burst of len+1 bytes
// under a single chip-select assertion, MSB first, sck idle low.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   start/write/addr/len  burst request; request fields latched when start is taken in IDLE
//   busy, done          burst in progress / one-cycle end-of-burst pulse
//   wdata/wvalid/wready write byte stream (handshake per byte)
//   rdata/rvalid/rready read byte stream (single holding register)
//   cs_n, sck, mosi, miso  SPI pins
module spi_mem_burst #(
  parameter int          ADDR_W  = 16,
  parameter int          LEN_W   = 8,
  parameter int          CLK_DIV = 1,
  parameter logic [7:0]  RD_CMD  = 8'h03,
  parameter logic [7:0]  WR_CMD  = 8'h02
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  input  logic [7:0]        wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [7:0]        rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              cs_n,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);

  localparam int SH_W  = 8 + ADDR_W;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CMD, WAIT_W, DATA, WAIT_R, FINISH} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sck_q, sck_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  logic half_end;
  logic hold_free;
  logic advance;

  assign half_end  = (div_q == DIV_LAST);
  // The holding register can take a new byte if empty or being drained this cycle.
  assign hold_free = !rvalid_q || rready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      sck_q    <= 1'b0;
      bit_q    <= '0;
      sh_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sck_q    <= sck_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sck_d    = sck_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q && !rready;
    wr_d     = wr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    advance  = 1'b0;

    case (state_q)
      IDLE: begin
        // A pending read byte blocks the next burst until it is consumed.
        if (start && !rvalid_q) begin
          wr_d    = write;
          len_d   = len;
          cnt_d   = '0;
          sh_d    = {(write ? WR_CMD : RD_CMD), addr};
          bit_d   = CNT_W'(SH_W);
          div_d   = '0;
          sck_d   = 1'b0;
          state_d = CMD;
        end
      end
      CMD, DATA: begin
        div_d = half_end ? '0 : div_q + DIV_W'(1);
        if (half_end && !sck_q) begin
          sck_d = 1'b1;
          if (state_q == DATA && !wr_q) rx_d = {rx_q[6:0], miso};
        end else if (half_end) begin
          // End of the high half: the next bit's low half starts here.
          sck_d = 1'b0;
          bit_d = bit_q - CNT_W'(1);
          sh_d  = sh_q << 1;
          if (bit_q == CNT_W'(1)) begin
            if (state_q == CMD) begin
              if (wr_q) begin
                state_d = WAIT_W;
              end else begin
                state_d = DATA;
                bit_d   = CNT_W'(8);
              end
            end else if (!wr_q && !hold_free) begin
              // Byte parks in rx_q until the holding register frees up.
              state_d = WAIT_R;
            end else begin
              if (!wr_q) begin
                rdata_d  = rx_q;
                rvalid_d = 1'b1;
              end
              advance = 1'b1;
            end
          end
        end
      end
      WAIT_W: begin
        if (wvalid) begin
          sh_d    = {wdata, {ADDR_W{1'b0}}};
          bit_d   = CNT_W'(8);
          div_d   = '0;
          sck_d   = 1'b0;
          state_d = DATA;
        end
      end
      WAIT_R: begin
        if (rready) begin
          rdata_d  = rx_q;
          rvalid_d = 1'b1;
          advance  = 1'b1;
        end
      end
      FINISH: begin
        div_d = half_end ? '0 : div_q + DIV_W'(1);
        if (half_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Byte boundary bookkeeping shared by DATA and WAIT_R.
    if (advance) begin
      div_d = '0;
      sck_d = 1'b0;
      bit_d = CNT_W'(8);
      if (cnt_q == len_q) begin
        state_d = FINISH;
      end else begin
        cnt_d   = cnt_q + LEN_W'(1);
        state_d = wr_q ? WAIT_W : DATA;
      end
    end
  end

  // Outputs
  always_comb begin
    cs_n   = (state_q == IDLE);
    busy   = (state_q != IDLE);
    wready = (state_q == WAIT_W);
    mosi   = 1'b0;
    if (state_q == CMD || (state_q == DATA && wr_q)) mosi = sh_q[SH_W-1];
    sck    = sck_q;
    done   = done_q;
    rdata  = rdata_q;
    rvalid = rvalid_q;
  end

endmodule

// File: tb/tb_spi_mem_burst.sv
// tb/tb_spi_mem_burst.sv - scoreboard bench for spi_mem_burst with serial RAM model
module tb_spi_mem_burst;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        start, write, busy, done, wvalid, wready, rvalid, rready;
  logic        cs_n, sck, mosi, miso;
  logic [15:0] addr;
  logic [7:0]  len, wdata, rdata;

  logic        s_start, s_busy, s_done, s_wready, s_rvalid, s_cs_n, s_sck, s_mosi;
  logic [23:0] s_addr;
  logic [7:0]  s_rdata;

  spi_mem_burst #(.ADDR_W(16), .LEN_W(8), .CLK_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .write(write), .addr(addr), .len(len),
    .busy(busy), .done(done), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso)
  );

  spi_mem_burst #(.ADDR_W(24), .LEN_W(8), .CLK_DIV(3)) u_dut24 (
    .clk(clk), .rst(rst), .start(s_start), .write(1'b0), .addr(s_addr), .len(8'd0),
    .busy(s_busy), .done(s_done), .wdata(8'h00), .wvalid(1'b0), .wready(s_wready),
    .rdata(s_rdata), .rvalid(s_rvalid), .rready(1'b1),
    .cs_n(s_cs_n), .sck(s_sck), .mosi(s_mosi), .miso(1'b0)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: condition not met (required true)", name);
  endtask

  // Reference memory and serial RAM contents
  logic [7:0]  ref_mem [65536];
  logic [7:0]  slv_mem [65536];
  logic [23:0] exp_hdr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  exp_wr [$];
  logic [7:0]  wsrc [$];
  int          wgap [$];

  // Serial RAM model: samples mosi on sck rise, drives miso after sck fall.
  int          nb = 0;
  logic [31:0] shv = '0;
  logic [15:0] sa = '0;
  logic        sw = 1'b0;
  logic        sck_ps = 1'b0;
  always @(negedge clk) begin
    if (cs_n) begin
      nb   = 0;
      miso = 1'b0;
    end else if (sck && !sck_ps) begin
      shv = {shv[30:0], mosi};
      nb++;
      if (nb == 24) begin
        sw = (shv[23:16] == 8'h02);
        sa = shv[15:0];
        if (exp_hdr.size() == 0) fail("hdr_expected");
        else chk("hdr", shv[23:0], exp_hdr.pop_front());
      end else if (nb > 24 && (nb - 24) % 8 == 0) begin
        if (sw) begin
          slv_mem[sa] = shv[7:0];
          if (exp_wr.size() == 0) fail("wr_expected");
          else chk("wr_byte", shv[7:0], exp_wr.pop_front());
        end
        sa++;
      end
    end else if (!sck && sck_ps && nb >= 24 && !sw) begin
      int idx;
      idx  = 7 - ((nb - 24) % 8);
      miso = slv_mem[sa][idx];
    end
    sck_ps = sck;
  end

  // Monitor: read scoreboard, done/sck counters, write-wait checks
  int   done_cnt = 0;
  int   rises = 0;
  logic sck_pm = 1'b0;
  logic hs_prev = 1'b0;
  always @(negedge clk) begin
    if (rvalid && rready) begin
      if (exp_rd.size() == 0) fail("rd_expected");
      else chk("rd_byte", rdata, exp_rd.pop_front());
    end
    if (done) done_cnt++;
    if (sck && !sck_pm) rises++;
    sck_pm = sck;
    if (wready) chk("wait_w_sck_cs", {sck, cs_n}, 2'b00);
    if (hs_prev) chk("wready_drop", wready, 1'b0);
    hs_prev = wvalid && wready;
  end

  // rready driver
  int hold = 0;
  bit rr_rand = 0;
  bit rr_off = 0;
  always @(posedge clk) begin
    #1;
    if (rr_off || hold > 0) begin
      rready = 1'b0;
      if (hold > 0) hold--;
    end else begin
      rready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Write byte producer; the gap counts from wready rising.
  initial begin
    wvalid = 1'b0;
    wdata  = 8'h00;
    forever begin
      int   g, cyc;
      logic [7:0] b;
      wait (wsrc.size() > 0);
      g = wgap.pop_front();
      b = wsrc.pop_front();
      cyc = 0;
      while (!wready && cyc < 5000) begin
        @(negedge clk);
        cyc++;
      end
      if (!wready) fail("wready_timeout");
      repeat (g) @(posedge clk);
      @(posedge clk); #1;
      wdata  = b;
      wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
    end
  end

  task automatic wait_done(input string name);
    int cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) fail(name);
  endtask

  task automatic burst(input logic wr, input logic [15:0] a, input logic [7:0] l,
                       input int gap, input bit bp);
    int d0, r0, r1, cyc;
    logic [7:0] b;
    exp_hdr.push_back({(wr ? 8'h02 : 8'h03), a});
    for (int i = 0; i <= int'(l); i++) begin
      if (wr) begin
        b = 8'($urandom);
        ref_mem[16'(int'(a) + i)] = b;
        exp_wr.push_back(b);
        wsrc.push_back(b);
        wgap.push_back((i == 1) ? gap : int'($urandom_range(0, 3)));
      end else begin
        exp_rd.push_back(ref_mem[16'(int'(a) + i)]);
      end
    end
    d0 = done_cnt;
    r0 = rises;
    @(posedge clk); #1;
    write = wr; addr = a; len = l; start = 1'b1;
    cyc = 0;
    while (!busy && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!busy) fail("start_timeout");
    if (bp) begin
      cyc = 0;
      while (!rvalid && cyc < 500) begin
        @(negedge clk);
        cyc++;
      end
      if (!rvalid) fail("bp_first_byte");
      hold = 40;
      repeat (36) @(negedge clk);
      r1 = rises;
      repeat (3) @(negedge clk);
      chk("bp_sck_stopped", rises - r1, 0);
      chk("bp_cs_busy", {cs_n, busy}, 2'b01);
    end
    wait_done("done_timeout");
    chk("cs_n_at_done", cs_n, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("sck_rises", rises - r0, 24 + 8 * (int'(l) + 1));
  endtask

  // 24-bit / CLK_DIV=3 instance observer
  int          run24 = 0, cyc24 = 0, falls24 = 0, cmd_cyc24 = -1, rises24 = 0, done24 = 0;
  logic        lvl24 = 1'b0;
  logic [31:0] hdr24 = '0;
  always @(negedge clk) begin
    if (s_done) done24++;
    if (s_cs_n) begin
      run24 = 0;
      lvl24 = 1'b0;
    end else begin
      if (s_sck != lvl24) begin
        chk("half_len24", run24, 3);
        if (s_sck) begin
          rises24++;
          if (rises24 <= 32) hdr24 = {hdr24[30:0], s_mosi};
        end else begin
          falls24++;
          if (falls24 == 32) cmd_cyc24 = cyc24;
        end
        run24 = 1;
        lvl24 = s_sck;
      end else begin
        run24++;
      end
      cyc24++;
    end
  end

  initial begin
    int d0, r0, cyc;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      ref_mem[i] = v;
      slv_mem[i] = v;
    end
    rst = 1'b1; start = 1'b0; write = 1'b0; addr = '0; len = '0;
    rready = 1'b1; s_start = 1'b0; s_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sck_mosi", {sck, mosi}, 2'b00);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_wready_rvalid", {wready, rvalid}, 2'b00);
    chk("rst_rdata", rdata, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed read: 0xA5, 0x5A, 0xFF from 0x1234
    ref_mem[16'h1234] = 8'hA5; slv_mem[16'h1234] = 8'hA5;
    ref_mem[16'h1235] = 8'h5A; slv_mem[16'h1235] = 8'h5A;
    ref_mem[16'h1236] = 8'hFF; slv_mem[16'h1236] = 8'hFF;
    burst(1'b0, 16'h1234, 8'd2, 0, 1'b0);

    // Directed write with a 5-cycle wvalid gap, then read it back
    burst(1'b1, 16'h00FF, 8'd1, 5, 1'b0);
    burst(1'b0, 16'h00FF, 8'd1, 0, 1'b0);

    // Read backpressure
    burst(1'b0, 16'h4000, 8'd3, 0, 1'b1);

    // Randomised bursts with random rready
    rr_rand = 1;
    for (int k = 0; k < 12; k++) begin
      burst(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom_range(0, 6)),
            int'($urandom_range(0, 6)), 1'b0);
    end
    rr_rand = 0;
    repeat (4) @(negedge clk);

    // Reset in the middle of the command phase
    d0 = done_cnt;
    r0 = rises;
    @(posedge clk); #1;
    write = 1'b0; addr = 16'h2222; len = 8'd2; start = 1'b1;
    cyc = 0;
    while ((rises - r0) < 10 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if ((rises - r0) < 10) fail("rst_mid_reach");
    #1;
    rst = 1'b1;
    start = 1'b0;
    #1;
    chk("rst_mid_cs_n", cs_n, 1'b1);
    chk("rst_mid_sck", sck, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    burst(1'b0, 16'h2222, 8'd2, 0, 1'b0);

    // len=0 reads with start held high; second start waits for rvalid to clear
    a = 16'h7777;
    d0 = done_cnt;
    exp_hdr.push_back({8'h03, a});
    exp_hdr.push_back({8'h03, a});
    exp_rd.push_back(ref_mem[a]);
    exp_rd.push_back(ref_mem[a]);
    rr_off = 1;
    @(posedge clk); #1;
    write = 1'b0; addr = a; len = 8'd0; start = 1'b1;
    wait_done("b2b_done1");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_held_idle", {cs_n, busy, rvalid}, 3'b101);
    end
    rr_off = 0;
    cyc = 0;
    while (!busy && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!busy) fail("b2b_second_start");
    wait_done("b2b_done2");
    repeat (4) @(negedge clk);
    chk("b2b_done_count", done_cnt - d0, 2);

    // 24-bit address, CLK_DIV=3
    @(posedge clk); #1;
    s_addr = 24'hABCDEF;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    cyc = 0;
    while (!s_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (!s_done) fail("d24_done_timeout");
    repeat (3) @(negedge clk);
    chk("d24_hdr", hdr24, 32'h03ABCDEF);
    chk("d24_cmd_cycles", cmd_cyc24, 192);
    chk("d24_rises", rises24, 40);
    chk("d24_done_once", done24, 1);
    chk("d24_idle", {s_cs_n, s_busy, s_sck}, 3'b100);

    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("hdr_queue_empty", exp_hdr.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule
